// File: rtl/temp_sample_sequencer_pkg.sv
// rtl/temp_sample_sequencer_pkg.sv - shared states and threshold defaults for the temperature sample sequencer
package temp_sample_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam logic [7:0] HIGH_DEFAULT_C = 8'd200;
    localparam logic [7:0] LOW_DEFAULT_C  = 8'd180;

endpackage

// File: rtl/temp_threshold_regs.sv
// rtl/temp_threshold_regs.sv - validated high/low threshold registers with reject pulse
module temp_threshold_regs
    import temp_sample_sequencer_pkg::*;
#(
    parameter int          N            = 8,
    parameter logic [N-1:0] HIGH_DEFAULT = N'(HIGH_DEFAULT_C),
    parameter logic [N-1:0] LOW_DEFAULT  = N'(LOW_DEFAULT_C)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [N-1:0] cfg_high,
    input  logic [N-1:0] cfg_low,
    output logic [N-1:0] temp_high,
    output logic [N-1:0] temp_low,
    output logic         cfg_err
);

    // A pair is only taken when it leaves a real hysteresis band; equal values are refused.
    always_ff @(posedge clk) begin
        if (reset) begin
            temp_high <= HIGH_DEFAULT;
            temp_low  <= LOW_DEFAULT;
            cfg_err   <= 1'b0;
        end else if (cfg_we) begin
            if (cfg_high > cfg_low) begin
                temp_high <= cfg_high;
                temp_low  <= cfg_low;
                cfg_err   <= 1'b0;
            end else begin
                cfg_err   <= 1'b1;
            end
        end else begin
            cfg_err <= 1'b0;
        end
    end

endmodule

// File: rtl/temp_sample_sequencer.sv
// rtl/temp_sample_sequencer.sv - round-robin ADC sequencer with per-channel averaging and threshold registers
module temp_sample_sequencer
    import temp_sample_sequencer_pkg::*;
#(
    parameter int           N            = 8,
    parameter int           CH           = 4,
    parameter int           AVG_LOG2     = 2,
    parameter int           TIMEOUT      = 255,
    parameter logic [N-1:0] HIGH_DEFAULT = N'(HIGH_DEFAULT_C),
    parameter logic [N-1:0] LOW_DEFAULT  = N'(LOW_DEFAULT_C)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  adc_start,
    output logic [$clog2(CH)-1:0] adc_ch,
    input  logic                  adc_done,
    input  logic [N-1:0]          adc_data,
    output logic [N-1:0]          temp_average,
    output logic [$clog2(CH)-1:0] avg_ch,
    output logic                  avg_valid,
    input  logic                  cfg_we,
    input  logic [N-1:0]          cfg_high,
    input  logic [N-1:0]          cfg_low,
    output logic [N-1:0]          temp_high,
    output logic [N-1:0]          temp_low,
    output logic                  cfg_err,
    output logic                  err_timeout
);

    localparam int CW = $clog2(CH);
    localparam int AW = N + AVG_LOG2;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'((1 << AVG_LOG2) - 1);

    state_t         state;
    logic [CW-1:0]  cur_ch;
    logic [AW-1:0]  acc;
    logic [SW-1:0]  sample_cnt;
    logic [TW-1:0]  wait_cnt;
    logic [AW-1:0]  acc_sum;
    logic [CW-1:0]  ch_next;

    assign acc_sum = acc + AW'(adc_data);
    assign ch_next = (cur_ch == CW'(CH - 1)) ? '0 : cur_ch + CW'(1);
    assign adc_ch  = cur_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur_ch       <= '0;
            acc          <= '0;
            sample_cnt   <= '0;
            wait_cnt     <= '0;
            adc_start    <= 1'b0;
            avg_valid    <= 1'b0;
            temp_average <= '0;
            avg_ch       <= '0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_START;
                        adc_start <= 1'b1;
                    end
                end
                ST_START: begin
                    adc_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (adc_done) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            // Average and strobe are registered so they appear while in EMIT.
                            acc          <= acc_sum;
                            temp_average <= acc_sum[AVG_LOG2 +: N];
                            avg_ch       <= cur_ch;
                            avg_valid    <= 1'b1;
                            state        <= ST_EMIT;
                        end else if (enable) begin
                            acc        <= acc_sum;
                            sample_cnt <= sample_cnt + SW'(1);
                            adc_start  <= 1'b1;
                            state      <= ST_START;
                        end else begin
                            // Disabled mid-channel: the partial average is dropped, channel kept.
                            acc        <= '0;
                            sample_cnt <= '0;
                            state      <= ST_IDLE;
                        end
                    end else if (wait_cnt == TW'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        acc         <= '0;
                        sample_cnt  <= '0;
                        cur_ch      <= ch_next;
                        if (enable) begin
                            adc_start <= 1'b1;
                            state     <= ST_START;
                        end else begin
                            state     <= ST_IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                ST_EMIT: begin
                    avg_valid  <= 1'b0;
                    acc        <= '0;
                    sample_cnt <= '0;
                    cur_ch     <= ch_next;
                    if (enable) begin
                        adc_start <= 1'b1;
                        state     <= ST_START;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    temp_threshold_regs #(
        .N            (N),
        .HIGH_DEFAULT (HIGH_DEFAULT),
        .LOW_DEFAULT  (LOW_DEFAULT)
    ) u_threshold_regs (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .temp_high (temp_high),
        .temp_low  (temp_low),
        .cfg_err   (cfg_err)
    );

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// tb/tb_temp_sample_sequencer.sv - directed self-checking bench for temp_sample_sequencer
module tb_temp_sample_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       adc_start;
    logic [1:0] adc_ch;
    logic       adc_done;
    logic [7:0] adc_data;
    logic [7:0] temp_average;
    logic [1:0] avg_ch;
    logic       avg_valid;
    logic       cfg_we;
    logic [7:0] cfg_high;
    logic [7:0] cfg_low;
    logic [7:0] temp_high;
    logic [7:0] temp_low;
    logic       cfg_err;
    logic       err_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    temp_sample_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .adc_start    (adc_start),
        .adc_ch       (adc_ch),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .temp_average (temp_average),
        .avg_ch       (avg_ch),
        .avg_valid    (avg_valid),
        .cfg_we       (cfg_we),
        .cfg_high     (cfg_high),
        .cfg_low      (cfg_low),
        .temp_high    (temp_high),
        .temp_low     (temp_low),
        .cfg_err      (cfg_err),
        .err_timeout  (err_timeout)
    );

    // ADC model: wait (bounded) for a start request, answer in the first WAIT cycle.
    task automatic conv(input logic [7:0] d, output bit ok, output logic [1:0] ch);
        ok = 1'b0;
        ch = 2'd0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (adc_start === 1'b1) begin
                ok = 1'b1;
                ch = adc_ch;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) begin
            @(negedge clk);
            adc_done = 1'b1;
            adc_data = d;
            @(negedge clk);
            adc_done = 1'b0;
        end
    endtask

    task automatic run_channel(input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3,
                               output bit ok, output logic [1:0] ch,
                               output logic v, output logic [7:0] a, output logic [1:0] ac);
        logic [7:0] ds [4];
        bit         o;
        logic [1:0] c;
        ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
        ok = 1'b1;
        ch = 2'd0;
        for (int k = 0; k < 4; k++) begin
            conv(ds[k], o, c);
            if (!o) ok = 1'b0;
            if (k == 0) ch = c;
            else if (c !== ch) ok = 1'b0;
        end
        v  = avg_valid;
        a  = temp_average;
        ac = avg_ch;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; adc_done = 1'b0; adc_data = 8'd0;
        cfg_we = 1'b0; cfg_high = 8'd0; cfg_low = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if ({adc_start, avg_valid, cfg_err, err_timeout} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {adc_start, avg_valid, cfg_err, err_timeout}); end
        checks++; if (temp_average !== 8'd0 || avg_ch !== 2'd0 || adc_ch !== 2'd0) begin
            failures++; $display("FAIL reset_data avg=%0d avg_ch=%0d adc_ch=%0d exp=0/0/0", temp_average, avg_ch, adc_ch); end
        checks++; if (temp_high !== 8'd200 || temp_low !== 8'd180) begin
            failures++; $display("FAIL reset_thresholds got=%0d/%0d exp=200/180", temp_high, temp_low); end
    endtask

    task automatic test_first_average();
        bit ok; logic [1:0] ch; logic v; logic [7:0] a; logic [1:0] ac;
        enable = 1'b1;
        run_channel(8'd10, 8'd11, 8'd12, 8'd13, ok, ch, v, a, ac);
        checks++; if (!ok || ch !== 2'd0) begin
            failures++; $display("FAIL first_adc_ch ok=%0d got=%0d exp=0", ok, ch); end
        checks++; if (v !== 1'b1 || a !== 8'd11 || ac !== 2'd0) begin
            failures++; $display("FAIL first_average valid=%b avg=%0d ch=%0d exp=1/11/0", v, a, ac); end
    endtask

    task automatic test_round_robin();
        logic [7:0] din  [4][4];
        logic [7:0] eavg [4];
        logic [1:0] ech  [4];
        bit ok; logic [1:0] ch; logic v; logic [7:0] a; logic [1:0] ac;
        din[0] = '{8'd0, 8'd0, 8'd0, 8'd3};          eavg[0] = 8'd0;   ech[0] = 2'd1;
        din[1] = '{8'd255, 8'd255, 8'd255, 8'd255};  eavg[1] = 8'd255; ech[1] = 2'd2;
        din[2] = '{8'd1, 8'd2, 8'd3, 8'd4};          eavg[2] = 8'd2;   ech[2] = 2'd3;
        din[3] = '{8'd100, 8'd101, 8'd102, 8'd103};  eavg[3] = 8'd101; ech[3] = 2'd0;
        for (int t = 0; t < 4; t++) begin
            run_channel(din[t][0], din[t][1], din[t][2], din[t][3], ok, ch, v, a, ac);
            checks++; if (!ok || ch !== ech[t]) begin
                failures++; $display("FAIL rr_adc_ch[%0d] ok=%0d got=%0d exp=%0d", t, ok, ch, ech[t]); end
            checks++; if (v !== 1'b1 || a !== eavg[t] || ac !== ech[t]) begin
                failures++; $display("FAIL rr_average[%0d] valid=%b avg=%0d ch=%0d exp=1/%0d/%0d", t, v, a, ac, eavg[t], ech[t]); end
        end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (avg_valid !== 1'b0 || temp_average !== 8'd101 || adc_start !== 1'b0) begin
            failures++; $display("FAIL rr_hold valid=%b avg=%0d start=%b exp=0/101/0", avg_valid, temp_average, adc_start); end
    endtask

    task automatic test_cfg();
        @(negedge clk); cfg_we = 1'b1; cfg_high = 8'd150; cfg_low = 8'd160;
        @(negedge clk); cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1 || temp_high !== 8'd200 || temp_low !== 8'd180) begin
            failures++; $display("FAIL cfg_reject err=%b thr=%0d/%0d exp=1/200/180", cfg_err, temp_high, temp_low); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin
            failures++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
        cfg_we = 1'b1; cfg_high = 8'd160; cfg_low = 8'd160;
        @(negedge clk); cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1 || temp_high !== 8'd200 || temp_low !== 8'd180) begin
            failures++; $display("FAIL cfg_equal err=%b thr=%0d/%0d exp=1/200/180", cfg_err, temp_high, temp_low); end
        @(negedge clk); cfg_we = 1'b1; cfg_high = 8'd170; cfg_low = 8'd140;
        @(negedge clk); cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b0 || temp_high !== 8'd170 || temp_low !== 8'd140) begin
            failures++; $display("FAIL cfg_accept err=%b thr=%0d/%0d exp=0/170/140", cfg_err, temp_high, temp_low); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); cfg_we = 1'b1; cfg_high = 8'd100; cfg_low = 8'd120;
        @(negedge clk);
        checks++; if (cfg_err !== 1'b1) begin
            failures++; $display("FAIL b2b_err_first got=%b exp=1", cfg_err); end
        @(negedge clk); cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1 || temp_high !== 8'd170) begin
            failures++; $display("FAIL b2b_err_second err=%b high=%0d exp=1/170", cfg_err, temp_high); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin
            failures++; $display("FAIL b2b_err_drop got=%b exp=0", cfg_err); end
        cfg_we = 1'b1; cfg_high = 8'd90; cfg_low = 8'd80;
        @(negedge clk); cfg_high = 8'd10; cfg_low = 8'd20;
        checks++; if (cfg_err !== 1'b0 || temp_high !== 8'd90 || temp_low !== 8'd80) begin
            failures++; $display("FAIL b2b_accept err=%b thr=%0d/%0d exp=0/90/80", cfg_err, temp_high, temp_low); end
        @(negedge clk); cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1 || temp_high !== 8'd90 || temp_low !== 8'd80) begin
            failures++; $display("FAIL b2b_reject err=%b thr=%0d/%0d exp=1/90/80", cfg_err, temp_high, temp_low); end
    endtask

    task automatic test_timeout();
        bit found; bit seen_valid; logic [1:0] ch;
        bit ok; logic v; logic [7:0] a; logic [1:0] ac;
        enable = 1'b1;
        found = 1'b0; ch = 2'd0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) begin found = 1'b1; ch = adc_ch; end
        end
        checks++; if (!found || ch !== 2'd1) begin
            failures++; $display("FAIL to_first_ch found=%0d got=%0d exp=1", found, ch); end
        seen_valid = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (avg_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++; if (err_timeout !== 1'b0) begin
            failures++; $display("FAIL to_early got=%b exp=0", err_timeout); end
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (avg_valid === 1'b1) seen_valid = 1'b1;
            if (adc_start === 1'b1) begin found = 1'b1; ch = adc_ch; end
        end
        checks++; if (!found || ch !== 2'd2 || err_timeout !== 1'b1) begin
            failures++; $display("FAIL to_next found=%0d ch=%0d err=%b exp=1/2/1", found, ch, err_timeout); end
        checks++; if (seen_valid) begin
            failures++; $display("FAIL to_no_strobe got=1 exp=0"); end
        run_channel(8'd20, 8'd20, 8'd20, 8'd20, ok, ch, v, a, ac);
        checks++; if (!ok || v !== 1'b1 || a !== 8'd20 || ac !== 2'd2 || err_timeout !== 1'b1) begin
            failures++; $display("FAIL to_recover ok=%0d valid=%b avg=%0d ch=%0d err=%b exp=1/1/20/2/1", ok, v, a, ac, err_timeout); end
    endtask

    task automatic test_disable();
        bit ok1, ok2, ok3; logic [1:0] c1, c2, c3; bit busy;
        bit ok; logic [1:0] ch; logic v; logic [7:0] a; logic [1:0] ac;
        conv(8'd50, ok1, c1);
        conv(8'd50, ok2, c2);
        enable = 1'b0;
        conv(8'd99, ok3, c3);
        checks++; if (!(ok1 && ok2 && ok3) || c1 !== 2'd3 || c3 !== 2'd3) begin
            failures++; $display("FAIL dis_inflight ok=%0d%0d%0d ch=%0d/%0d exp=111/3/3", ok1, ok2, ok3, c1, c3); end
        busy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (adc_start !== 1'b0 || avg_valid !== 1'b0) busy = 1'b1;
        end
        checks++; if (busy) begin
            failures++; $display("FAIL dis_idle got=active exp=idle"); end
        enable = 1'b1;
        run_channel(8'd40, 8'd41, 8'd42, 8'd43, ok, ch, v, a, ac);
        checks++; if (!ok || ch !== 2'd3 || v !== 1'b1 || a !== 8'd41 || ac !== 2'd3) begin
            failures++; $display("FAIL dis_restart ok=%0d ch=%0d valid=%b avg=%0d avg_ch=%0d exp=1/3/1/41/3", ok, ch, v, a, ac); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [1:0] ch; bit stray;
        conv(8'd7, ok, ch);
        checks++; if (!ok || ch !== 2'd0) begin
            failures++; $display("FAIL rst_wrap_ch ok=%0d got=%0d exp=0", ok, ch); end
        @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({adc_start, avg_valid, cfg_err, err_timeout} !== 4'b0000 || temp_average !== 8'd0 || avg_ch !== 2'd0) begin
            failures++; $display("FAIL rst_mid_out flags=%b avg=%0d ch=%0d exp=0000/0/0", {adc_start, avg_valid, cfg_err, err_timeout}, temp_average, avg_ch); end
        checks++; if (temp_high !== 8'd200 || temp_low !== 8'd180 || adc_ch !== 2'd0) begin
            failures++; $display("FAIL rst_mid_thr thr=%0d/%0d adc_ch=%0d exp=200/180/0", temp_high, temp_low, adc_ch); end
        adc_done = 1'b1; adc_data = 8'd250;
        @(negedge clk);
        adc_done = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (avg_valid !== 1'b0 || adc_start !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin
            failures++; $display("FAIL rst_stray_done got=active exp=idle"); end
    endtask

    initial begin
        test_reset();
        test_first_average();
        test_round_robin();
        test_cfg();
        test_back_to_back();
        test_timeout();
        test_disable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
